// File: rtl/cmd_frame_parser_pkg.sv
// cmd_frame_parser_pkg: frame constants, address window and parser state encoding
package cmd_frame_parser_pkg;
  localparam logic [7:0] HDR0 = 8'hEB;
  localparam logic [7:0] HDR1 = 8'h90;
  localparam logic [7:0] ADDR_MIN = 8'h02;
  localparam logic [7:0] ADDR_MAX = 8'h15;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd50000;
  localparam logic [3:0] WR_PULSE_CYC_DEF = 4'd2;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR1  = 3'd1,
    S_ADDR  = 3'd2,
    S_DHI   = 3'd3,
    S_DLO   = 3'd4,
    S_CHK   = 3'd5,
    S_WRITE = 3'd6
  } state_t;
  function automatic logic addr_in_range(input logic [7:0] a);
    return (a >= ADDR_MIN) && (a <= ADDR_MAX);
  endfunction
endpackage

// File: rtl/cmd_frame_parser_wrap_cnt16.sv
// wrap_cnt16: 16-bit wrapping event counter with synchronous clear
module wrap_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;
  // next count, wraps naturally at 16 bits
  always_comb cnt_d = inc ? cnt_q + 16'd1 : cnt_q;
  // count register
  always_ff @(posedge clk)
    cnt_q <= rst ? 16'd0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: assembles 6-byte telecommand frames and issues register writes
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter logic [3:0]  WR_PULSE_CYC = WR_PULSE_CYC_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_byte_in,
  input  logic        rx_valid_in,
  output logic        wr_out,
  output logic [7:0]  wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        busy_out,
  output logic [15:0] frame_ok_cnt_out,
  output logic [15:0] chk_err_cnt_out,
  output logic [15:0] addr_err_cnt_out,
  output logic [15:0] timeout_cnt_out
);
  state_t      state_q, state_d;
  logic        busy_q;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] gap_q, gap_d;
  logic [3:0]  pcnt_q, pcnt_d;
  logic        in_frame, tmo, chk_ok, rng_ok, at_chk, accept, chk_inc, aerr_inc, pulse_done;
  assign in_frame   = (state_q != S_IDLE) && (state_q != S_WRITE);
  assign tmo        = in_frame && !rx_valid_in && (gap_q == TIMEOUT_CYC - 16'd1);
  assign chk_ok     = sum_q == rx_byte_in;
  assign rng_ok     = addr_in_range(addr_q);
  assign at_chk     = rx_valid_in && (state_q == S_CHK);
  assign accept     = at_chk && chk_ok && rng_ok;
  assign chk_inc    = at_chk && !chk_ok;
  assign aerr_inc   = at_chk && chk_ok && !rng_ok;
  assign pulse_done = pcnt_q == WR_PULSE_CYC;
  // state register; busy follows the next state so both change on the same edge
  always_ff @(posedge clk_in) begin
    state_q <= rst_in ? S_IDLE : state_d;
    busy_q  <= rst_in ? 1'b0 : (state_d != S_IDLE);
  end
  // next state: a timeout drops the frame, bytes only advance the hunt outside S_WRITE
  always_comb begin
    state_d = state_q;
    if (tmo)
      state_d = S_IDLE;
    else if (rx_valid_in)
      case (state_q)
        S_IDLE:  state_d = (rx_byte_in == HDR0) ? S_HDR1 : S_IDLE;
        S_HDR1:  state_d = (rx_byte_in == HDR1) ? S_ADDR : (rx_byte_in == HDR0) ? S_HDR1 : S_IDLE;
        S_ADDR:  state_d = S_DHI;
        S_DHI:   state_d = S_DLO;
        S_DLO:   state_d = S_CHK;
        S_CHK:   state_d = (chk_ok && rng_ok) ? S_WRITE : S_IDLE;
        default: state_d = state_q;
      endcase
    if ((state_q == S_WRITE) && pulse_done)
      state_d = S_IDLE;
  end
  // field capture, running checksum, gap timer and write strobe
  always_comb begin
    gap_d     = (rx_valid_in || !in_frame || tmo) ? 16'd0 : gap_q + 16'd1;
    addr_d    = (rx_valid_in && state_q == S_ADDR) ? rx_byte_in : addr_q;
    sum_d     = !rx_valid_in ? sum_q :
                (state_q == S_ADDR) ? rx_byte_in :
                (state_q == S_DHI || state_q == S_DLO) ? sum_q + rx_byte_in : sum_q;
    data_d    = {(rx_valid_in && state_q == S_DHI) ? rx_byte_in : data_q[15:8],
                 (rx_valid_in && state_q == S_DLO) ? rx_byte_in : data_q[7:0]};
    wr_addr_d = accept ? addr_q : wr_addr_q;
    wr_data_d = accept ? data_q : wr_data_q;
    wr_d      = accept || ((state_q == S_WRITE) && !pulse_done);
    pcnt_d    = accept ? 4'd1 : ((state_q == S_WRITE) && !pulse_done) ? pcnt_q + 4'd1 : 4'd0;
  end
  // datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_q      <= 1'b0;
      addr_q    <= 8'd0;
      sum_q     <= 8'd0;
      data_q    <= 16'd0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 16'd0;
      gap_q     <= 16'd0;
      pcnt_q    <= 4'd0;
    end else begin
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      data_q    <= data_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      gap_q     <= gap_d;
      pcnt_q    <= pcnt_d;
    end
  end
  wrap_cnt16 u_ok_cnt   (.clk(clk_in), .rst(rst_in), .inc(accept),   .cnt(frame_ok_cnt_out));
  wrap_cnt16 u_chk_cnt  (.clk(clk_in), .rst(rst_in), .inc(chk_inc),  .cnt(chk_err_cnt_out));
  wrap_cnt16 u_aerr_cnt (.clk(clk_in), .rst(rst_in), .inc(aerr_inc), .cnt(addr_err_cnt_out));
  wrap_cnt16 u_tmo_cnt  (.clk(clk_in), .rst(rst_in), .inc(tmo),      .cnt(timeout_cnt_out));
  assign wr_out      = wr_q;
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign busy_out    = busy_q;
endmodule

// File: doc/cmd_frame_parser.md
Name: cmd_frame_parser

Overview:
- Upstream feeder of the configuration register bank.
- Consumes the byte stream from the telecommand UART receiver and assembles fixed 6-byte command frames.
- Validates header, checksum and address range, then issues a register write (strobe, address, data) to the configuration register bank.
- Keeps 16-bit wrapping statistics counters for housekeeping readout.

Parameters:
- HDR0, 8'hEB, first frame header byte
- HDR1, 8'h90, second frame header byte
- ADDR_MIN, 8'h02, lowest accepted register address
- ADDR_MAX, 8'h15, highest accepted register address
- TIMEOUT_CYC, 16'd50000, maximum idle gap between bytes inside a frame (1 ms at 50 MHz)
- WR_PULSE_CYC, 4'd2, width of the write strobe in clocks (legal range 1..15)

Ports:
- clk_in  in  1  system clock, 50 MHz
- rst_in  in  1  synchronous active-high reset
- rx_byte_in  in  8  received byte
- rx_valid_in  in  1  one-cycle strobe; rx_byte_in is valid in the same cycle
- wr_out  out  1  register write strobe
- wr_addr_out  out  8  register address
- wr_data_out  out  16  register data
- busy_out  out  1  high whenever state != S_IDLE
- frame_ok_cnt_out  out  16  count of accepted frames
- chk_err_cnt_out  out  16  count of checksum failures
- addr_err_cnt_out  out  16  count of out-of-range addresses
- timeout_cnt_out  out  16  count of inter-byte timeouts

Behaviour:
- Clock and reset: single clock clk_in; synchronous active-high reset rst_in.
- Reset: all outputs, counters and internal registers go to 0; state goes to S_IDLE.
- Frame format: HDR0, HDR1, ADDR, DATA_HI, DATA_LO, CHK.
  - CHK = (ADDR + DATA_HI + DATA_LO) mod 256, computed as an 8-bit running sum.
- FSM states and transitions (advance only on rx_valid_in):
  - S_IDLE: byte==HDR0 -> S_HDR1; otherwise stay.
  - S_HDR1: byte==HDR1 -> S_ADDR; byte==HDR0 -> stay (resync); otherwise -> S_IDLE.
  - S_ADDR: latch address, seed the sum -> S_DHI.
  - S_DHI: latch data[15:8], add to sum -> S_DLO.
  - S_DLO: latch data[7:0], add to sum -> S_CHK.
  - S_CHK, checksum mismatch: chk_err_cnt +1 -> S_IDLE.
  - S_CHK, checksum match but address outside [ADDR_MIN, ADDR_MAX]: addr_err_cnt +1 -> S_IDLE.
  - S_CHK, otherwise: load wr_addr_out/wr_data_out, frame_ok_cnt +1 -> S_WRITE.
  - S_WRITE: wr_out=1 for exactly WR_PULSE_CYC clocks -> S_IDLE.
- Write output timing and stability:
  - wr_out first rises in the clock after the CHK byte's rx_valid_in.
  - wr_addr_out/wr_data_out update in that same edge, before wr_out rises.
  - They hold their value until the next accepted frame, so the address is still stable on the cycle after wr_out falls (the falling edge of the write strobe is counted by the register bank).
- Rejected frames never change wr_addr_out/wr_data_out and never assert wr_out.
- Bytes arriving during S_WRITE are discarded and do not start hunting.
- Timeout:
  - Gap counter clears on every rx_valid_in and in S_IDLE/S_WRITE.
  - It increments in S_HDR1..S_CHK while no byte arrives.
  - When it reaches TIMEOUT_CYC: state -> S_IDLE and timeout_cnt +1.
  - If rx_valid_in coincides with the timeout cycle, the byte wins: it is processed normally and no timeout is counted.
- Counters: 16-bit, wrap 16'hFFFF -> 16'h0000, never saturate.
- Reset mid-frame or mid-write: wr_out drops in the next cycle, partial frame is lost, counters clear.
- busy_out is registered together with the state (same edge).

Decomposition:
- Shared package/include (alongside the existing register defaults):
  - header constants HDR0/HDR1
  - ADDR_MIN/ADDR_MAX, matching the configuration register map 8'h02..8'h15
  - state encoding S_IDLE..S_WRITE (3-bit)
- No sub-module needed. The four statistics counters may use one small shared cell, wrap_cnt16 (16-bit counter with synchronous clear and increment enable), instantiated four times.

Test Plan:
- Valid frame: bytes EB 90 04 12 34 4A, spaced 10 cycles apart -> wr_out high 2 cycles starting 1 clock after the last byte; wr_addr_out=8'h04, wr_data_out=16'h1234, held afterwards; frame_ok_cnt_out=1.
- Bad checksum: EB 90 04 12 34 4B -> no wr_out; chk_err_cnt_out=1; wr_addr_out/wr_data_out unchanged from the previous frame.
- Out-of-range address: EB 90 16 00 01 17 -> no wr_out; addr_err_cnt_out=1. Also EB 90 02 00 00 02 -> accepted (lower bound).
- Resync and timeout:
  - EB EB 90 03 00 55 58 -> accepted, wr_data_out=16'h0055.
  - EB 90 03, then 50000 idle cycles -> timeout_cnt_out=1, busy_out=0.
  - A byte exactly on the timeout cycle -> no timeout counted.
- Reset mid-frame: EB 90 05, rst_in for 1 cycle, then a complete valid frame -> all counters 0 before that frame, then frame_ok_cnt_out=1 and the frame is written correctly.
- Wrap and back-to-back:
  - Preload via 65535 good frames (or force), then one more -> frame_ok_cnt_out=16'h0000.
  - Back-to-back frames with 1-cycle byte spacing -> every frame is written; a byte landing during S_WRITE is dropped.
